// File: rtl/datapath_types.sv
// Shared writeback types: result/index widths, scalar source ids and the holding-buffer entry.
// Also provides the mod-3 source increment used by the round-robin search.
package datapath_types;
    localparam int WB_DATA_W = 32;
    localparam int WB_REG_W  = 5;
    localparam int WB_MREG_W = 4;

    typedef logic [WB_DATA_W-1:0] word_t;
    typedef logic [WB_REG_W-1:0]  regbits_t;
    typedef logic [WB_MREG_W-1:0] matbits_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_SLS = 2'd1,
        WB_BFU = 2'd2
    } wb_src_t;

    typedef struct packed {
        logic     valid;
        regbits_t rd;
        word_t    data;
    } wb_entry_t;

    function automatic wb_src_t wb_src_add(input wb_src_t base, input logic [1:0] off);
        logic [2:0] sum;
        logic [2:0] adj;
        sum = {1'b0, base} + {1'b0, off};
        adj = (sum >= 3'd3) ? (sum - 3'd3) : sum;
        return wb_src_t'(adj[1:0]);
    endfunction
endpackage

// File: rtl/writeback_arbiter_rr.sv
// 3-way round-robin arbiter: grant is combinational from requests, pointer moves to winner+1.
// Latency: same-cycle grant; no backpressure of its own (a request simply waits for its turn).
module rr_arbiter3
    import datapath_types::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_req,
    output logic [2:0] o_gnt,
    output logic       o_gnt_vld
);
    wb_src_t r_ptr;
    wb_src_t w_sel;

    // Scan farthest-first so the request nearest the pointer is the last assignment and wins.
    always_comb begin
        w_sel     = r_ptr;
        o_gnt_vld = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (i_req[wb_src_add(r_ptr, 2'(k))]) begin
                w_sel     = wb_src_add(r_ptr, 2'(k));
                o_gnt_vld = 1'b1;
            end
        end
        o_gnt = o_gnt_vld ? (3'b001 << w_sel) : 3'b000;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= WB_ALU;
        end else if (o_gnt_vld) begin
            r_ptr <= wb_src_add(w_sel, 2'd1);
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: RR-arbitrated scalar RF write port plus GEMM-first matrix scoreboard-clear port.
// Latency 1 cycle from accept to output; 1-entry buffer per source, ready drops while held and not draining. WB_PERF_EN adds perf counters.
module writeback_arbiter
    import datapath_types::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_W  = WB_REG_W,
    parameter int MREG_W = WB_MREG_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              sls_valid,
    input  logic [REG_W-1:0]  sls_rd,
    input  logic [DATA_W-1:0] sls_data,
    output logic              sls_ready,
    input  logic              bfu_valid,
    input  logic [REG_W-1:0]  bfu_rd,
    input  logic [DATA_W-1:0] bfu_data,
    output logic              bfu_ready,
    input  logic              mls_done_valid,
    input  logic [MREG_W-1:0] mls_md,
    output logic              mls_done_ready,
    input  logic              gemm_done_valid,
    input  logic [MREG_W-1:0] gemm_md,
    output logic              gemm_done_ready,
    output logic              rf_wen,
    output logic [REG_W-1:0]  rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mclr_valid,
    output logic [MREG_W-1:0] mclr_idx
`ifdef WB_PERF_EN
    ,
    output logic [31:0]       perf_wb_count,
    output logic [31:0]       perf_conflict_cycles
`endif
);
    wb_entry_t  r_buf [3];
    regbits_t   w_in_rd [3];
    word_t      w_in_dat [3];
    logic [2:0] w_in_vld;
    logic [2:0] w_req;
    logic [2:0] w_gnt;
    logic [2:0] w_drain;
    logic [2:0] w_rdy;
    logic       w_gnt_vld;

    assign w_in_vld    = {bfu_valid, sls_valid, alu_valid};
    assign w_in_rd[0]  = alu_rd;
    assign w_in_rd[1]  = sls_rd;
    assign w_in_rd[2]  = bfu_rd;
    assign w_in_dat[0] = alu_data;
    assign w_in_dat[1] = sls_data;
    assign w_in_dat[2] = bfu_data;

    // x0 results never compete: they leave the buffer on the next edge without a grant.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_req[i]   = r_buf[i].valid && (r_buf[i].rd != '0);
            w_drain[i] = r_buf[i].valid && ((r_buf[i].rd == '0) || w_gnt[i]);
            w_rdy[i]   = !r_buf[i].valid || w_drain[i];
        end
    end

    assign alu_ready = w_rdy[0];
    assign sls_ready = w_rdy[1];
    assign bfu_ready = w_rdy[2];

    rr_arbiter3 u_rr (
        .i_clk     (CLK),
        .i_rst_n   (nRST),
        .i_req     (w_req),
        .o_gnt     (w_gnt),
        .o_gnt_vld (w_gnt_vld)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 3; i++) r_buf[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_in_vld[i] && w_rdy[i]) begin
                    r_buf[i] <= '{valid: 1'b1, rd: w_in_rd[i], data: w_in_dat[i]};
                end else if (w_drain[i]) begin
                    r_buf[i].valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rf_rd    = '0;
        rf_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_gnt[i]) begin
                rf_rd    = r_buf[i].rd;
                rf_wdata = r_buf[i].data;
            end
        end
    end
    assign rf_wen = w_gnt_vld;

    logic       r_mls_vld;
    logic       r_gemm_vld;
    matbits_t   r_mls_md;
    matbits_t   r_gemm_md;
    logic [1:0] r_mls_loss;
    logic       w_gemm_win;
    logic       w_mls_win;

    // GEMM wins unless MLS has already lost two contended cycles back to back.
    assign w_gemm_win      = r_gemm_vld && !(r_mls_vld && (r_mls_loss == 2'd2));
    assign w_mls_win       = r_mls_vld && !w_gemm_win;
    assign gemm_done_ready = !r_gemm_vld || w_gemm_win;
    assign mls_done_ready  = !r_mls_vld || w_mls_win;
    assign mclr_valid      = w_gemm_win || w_mls_win;
    assign mclr_idx        = w_gemm_win ? r_gemm_md : (w_mls_win ? r_mls_md : '0);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mls_vld  <= 1'b0;
            r_gemm_vld <= 1'b0;
            r_mls_md   <= '0;
            r_gemm_md  <= '0;
            r_mls_loss <= 2'd0;
        end else begin
            if (gemm_done_valid && gemm_done_ready) begin
                r_gemm_vld <= 1'b1;
                r_gemm_md  <= gemm_md;
            end else if (w_gemm_win) begin
                r_gemm_vld <= 1'b0;
            end
            if (mls_done_valid && mls_done_ready) begin
                r_mls_vld <= 1'b1;
                r_mls_md  <= mls_md;
            end else if (w_mls_win) begin
                r_mls_vld <= 1'b0;
            end
            if (w_mls_win) begin
                r_mls_loss <= 2'd0;
            end else if (r_mls_vld && w_gemm_win) begin
                r_mls_loss <= r_mls_loss + 2'd1;
            end
        end
    end

`ifdef WB_PERF_EN
    logic w_conflict;
    assign w_conflict = (w_req[0] && w_req[1]) || (w_req[0] && w_req[2]) || (w_req[1] && w_req[2]);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_wb_count        <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (rf_wen && (perf_wb_count != '1)) perf_wb_count <= perf_wb_count + 32'd1;
            if (w_conflict && (perf_conflict_cycles != '1)) perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations, then random traffic vs a queue-level model.
module tb_writeback_arbiter;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        alu_valid = 1'b0, sls_valid = 1'b0, bfu_valid = 1'b0;
    logic [4:0]  alu_rd = '0, sls_rd = '0, bfu_rd = '0;
    logic [31:0] alu_data = '0, sls_data = '0, bfu_data = '0;
    logic        alu_ready, sls_ready, bfu_ready;
    logic        mls_done_valid = 1'b0, gemm_done_valid = 1'b0;
    logic [3:0]  mls_md = '0, gemm_md = '0;
    logic        mls_done_ready, gemm_done_ready;
    logic        rf_wen, mclr_valid;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [3:0]  mclr_idx;
`ifdef WB_PERF_EN
    logic [31:0] perf_wb_count, perf_conflict_cycles;
`endif

    writeback_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .sls_valid(sls_valid), .sls_rd(sls_rd), .sls_data(sls_data), .sls_ready(sls_ready),
        .bfu_valid(bfu_valid), .bfu_rd(bfu_rd), .bfu_data(bfu_data), .bfu_ready(bfu_ready),
        .mls_done_valid(mls_done_valid), .mls_md(mls_md), .mls_done_ready(mls_done_ready),
        .gemm_done_valid(gemm_done_valid), .gemm_md(gemm_md), .gemm_done_ready(gemm_done_ready),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .mclr_valid(mclr_valid), .mclr_idx(mclr_idx)
`ifdef WB_PERF_EN
        , .perf_wb_count(perf_wb_count), .perf_conflict_cycles(perf_conflict_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus, indexed 0=ALU 1=SLS 2=BFU.
    bit          in_v [3];
    logic [4:0]  in_rd [3];
    logic [31:0] in_dat [3];
    bit          in_mv, in_gv;
    logic [3:0]  in_mmd, in_gmd;

    // Model: what each source currently has waiting, whose turn it is, how long MLS has waited.
    bit          m_held [3];
    logic [4:0]  m_rd [3];
    logic [31:0] m_dat [3];
    int          m_ptr;
    bit          m_mh, m_gh;
    logic [3:0]  m_mmd, m_gmd;
    int          m_mls_waits;
    longint      m_pwb, m_pconf;

    int e_gnt, e_mwin, e_pending;
    bit e_rdy [3];
    bit e_mrdy, e_grdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int s = 0; s < 3; s++) begin
            in_v[s] = 1'b0; in_rd[s] = '0; in_dat[s] = '0;
        end
        in_mv = 1'b0; in_gv = 1'b0; in_mmd = '0; in_gmd = '0;
    endtask

    task automatic apply();
        alu_valid = in_v[0]; alu_rd = in_rd[0]; alu_data = in_dat[0];
        sls_valid = in_v[1]; sls_rd = in_rd[1]; sls_data = in_dat[1];
        bfu_valid = in_v[2]; bfu_rd = in_rd[2]; bfu_data = in_dat[2];
        mls_done_valid = in_mv; mls_md = in_mmd;
        gemm_done_valid = in_gv; gemm_md = in_gmd;
    endtask

    task automatic model_eval();
        int s;
        e_gnt = -1;
        e_pending = 0;
        for (int k = 0; k < 3; k++) begin
            s = (m_ptr + k) % 3;
            if (m_held[s] && m_rd[s] != 0) begin
                e_pending++;
                if (e_gnt < 0) e_gnt = s;
            end
        end
        for (int j = 0; j < 3; j++) e_rdy[j] = !m_held[j] || (m_rd[j] == 0) || (e_gnt == j);
        e_mwin = -1;
        if (m_mh && (!m_gh || m_mls_waits >= 2)) e_mwin = 1;
        else if (m_gh) e_mwin = 0;
        e_grdy = !m_gh || (e_mwin == 0);
        e_mrdy = !m_mh || (e_mwin == 1);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_held[s] = 1'b0; m_rd[s] = '0; m_dat[s] = '0;
        end
        m_ptr = 0; m_mh = 1'b0; m_gh = 1'b0; m_mmd = '0; m_gmd = '0;
        m_mls_waits = 0; m_pwb = 0; m_pconf = 0;
        model_eval();
    endtask

    task automatic model_next();
        if (e_gnt >= 0 && m_pwb < 64'hFFFF_FFFF) m_pwb++;
        if (e_pending >= 2 && m_pconf < 64'hFFFF_FFFF) m_pconf++;
        for (int s = 0; s < 3; s++) begin
            if (in_v[s] && e_rdy[s]) begin
                m_held[s] = 1'b1; m_rd[s] = in_rd[s]; m_dat[s] = in_dat[s];
            end else if (e_rdy[s]) begin
                m_held[s] = 1'b0;
            end
        end
        if (e_gnt >= 0) m_ptr = (e_gnt + 1) % 3;
        if (e_mwin == 1) m_mls_waits = 0;
        else if (e_mwin == 0 && m_mh) m_mls_waits++;
        if (in_gv && e_grdy) begin m_gh = 1'b1; m_gmd = in_gmd; end
        else if (e_grdy) m_gh = 1'b0;
        if (in_mv && e_mrdy) begin m_mh = 1'b1; m_mmd = in_mmd; end
        else if (e_mrdy) m_mh = 1'b0;
    endtask

    task automatic check_all();
        logic [4:0]  x_rd;
        logic [31:0] x_dat;
        logic [3:0]  x_midx;
        x_rd = '0; x_dat = '0; x_midx = '0;
        if (e_gnt >= 0) begin x_rd = m_rd[e_gnt]; x_dat = m_dat[e_gnt]; end
        if (e_mwin == 0) x_midx = m_gmd;
        if (e_mwin == 1) x_midx = m_mmd;
        chk("rf_wen", 32'(rf_wen), 32'(e_gnt >= 0));
        chk("rf_rd", 32'(rf_rd), 32'(x_rd));
        chk("rf_wdata", rf_wdata, x_dat);
        chk("mclr_valid", 32'(mclr_valid), 32'(e_mwin >= 0));
        chk("mclr_idx", 32'(mclr_idx), 32'(x_midx));
        chk("alu_ready", 32'(alu_ready), 32'(e_rdy[0]));
        chk("sls_ready", 32'(sls_ready), 32'(e_rdy[1]));
        chk("bfu_ready", 32'(bfu_ready), 32'(e_rdy[2]));
        chk("gemm_ready", 32'(gemm_done_ready), 32'(e_grdy));
        chk("mls_ready", 32'(mls_done_ready), 32'(e_mrdy));
`ifdef WB_PERF_EN
        chk("perf_wb", perf_wb_count, m_pwb[31:0]);
        chk("perf_conf", perf_conflict_cycles, m_pconf[31:0]);
`endif
    endtask

    // Drive the current stimulus across one rising edge, then check 1 ns later.
    task automatic cycle();
        apply();
        @(posedge CLK);
        model_next();
        #1;
        model_eval();
        check_all();
    endtask

    task automatic do_reset();
        clear_inputs();
        apply();
        nRST = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wen", 32'(rf_wen), 32'd0);
        chk("rst_rd", 32'(rf_rd), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_mclr", 32'(mclr_valid), 32'd0);
        chk("rst_midx", 32'(mclr_idx), 32'd0);
        chk("rst_ready", 32'({alu_ready, sls_ready, bfu_ready, mls_done_ready, gemm_done_ready}), 32'h1F);
`ifdef WB_PERF_EN
        chk("rst_perf", perf_wb_count | perf_conflict_cycles, 32'd0);
`endif
        nRST = 1'b1;
        cycle();
        chk("idle_wen", 32'(rf_wen), 32'd0);
    endtask

    task automatic set_scalar(input int s, input logic [4:0] rd, input logic [31:0] dat);
        in_v[s] = 1'b1; in_rd[s] = rd; in_dat[s] = dat;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Single write
        set_scalar(0, 5'd5, 32'hDEADBEEF);
        cycle();
        chk("single_wen", 32'(rf_wen), 32'd1);
        chk("single_rd", 32'(rf_rd), 32'd5);
        chk("single_data", rf_wdata, 32'hDEADBEEF);
        clear_inputs();
        cycle();
        chk("single_once", 32'(rf_wen), 32'd0);

        // Three-way contention from pointer at ALU; a new SLS result waits for its slot
        do_reset();
        set_scalar(0, 5'd1, 32'h11); set_scalar(1, 5'd2, 32'h22); set_scalar(2, 5'd3, 32'h33);
        cycle();
        chk("rr_first", 32'(rf_rd), 32'd1);
        chk("rr_sls_busy", 32'(sls_ready), 32'd0);
        chk("rr_bfu_busy", 32'(bfu_ready), 32'd0);
        clear_inputs();
        set_scalar(1, 5'd9, 32'h99);
        cycle();
        chk("rr_second", 32'(rf_rd), 32'd2);
        chk("rr_sls_free", 32'(sls_ready), 32'd1);
        cycle();
        chk("rr_third", 32'(rf_rd), 32'd3);
        clear_inputs();
        cycle();
        chk("rr_refused_then_taken", 32'(rf_rd), 32'd9);
        chk("rr_data9", rf_wdata, 32'h99);
        cycle();
        chk("rr_idle", 32'(rf_wen), 32'd0);

        // x0 drop leaves the pointer at ALU
        do_reset();
        set_scalar(1, 5'd0, 32'h1234);
        cycle();
        chk("x0_no_wen", 32'(rf_wen), 32'd0);
        chk("x0_ready", 32'(sls_ready), 32'd1);
        clear_inputs();
        set_scalar(0, 5'd4, 32'h44); set_scalar(2, 5'd6, 32'h66);
        cycle();
        chk("x0_alu_first", 32'(rf_rd), 32'd4);
        clear_inputs();
        cycle();
        chk("x0_bfu_next", 32'(rf_rd), 32'd6);

        // Matrix priority with bounded MLS starvation
        do_reset();
        in_gv = 1'b1; in_gmd = 4'd7; in_mv = 1'b1; in_mmd = 4'd3;
        cycle(); chk("mat_1", 32'(mclr_idx), 32'd7);
        cycle(); chk("mat_2", 32'(mclr_idx), 32'd7);
        cycle(); chk("mat_3_mls", 32'(mclr_idx), 32'd3);
        clear_inputs();
        cycle(); chk("mat_4", 32'(mclr_idx), 32'd7);
        cycle(); chk("mat_idle", 32'(mclr_valid), 32'd0);
        in_mv = 1'b1; in_mmd = 4'd9;
        cycle();
        chk("mls_iso_v", 32'(mclr_valid), 32'd1);
        chk("mls_iso_idx", 32'(mclr_idx), 32'd9);
        clear_inputs();
        cycle();
        chk("mls_iso_once", 32'(mclr_valid), 32'd0);

        // Asynchronous reset between edges while entries are held
        do_reset();
        set_scalar(0, 5'd1, 32'hA1); set_scalar(1, 5'd2, 32'hA2); set_scalar(2, 5'd3, 32'hA3);
        in_gv = 1'b1; in_gmd = 4'd5;
        cycle();
        clear_inputs();
        apply();
        #2 nRST = 1'b0;
        #1;
        model_reset();
        chk("arst_wen", 32'(rf_wen), 32'd0);
        chk("arst_rd", 32'(rf_rd), 32'd0);
        chk("arst_data", rf_wdata, 32'd0);
        chk("arst_mclr", 32'(mclr_valid), 32'd0);
        chk("arst_ready", 32'({alu_ready, sls_ready, bfu_ready, mls_done_ready, gemm_done_ready}), 32'h1F);
        #1 nRST = 1'b1;
        repeat (3) begin
            cycle();
            chk("arst_no_stale", 32'(rf_wen | mclr_valid), 32'd0);
        end

`ifdef WB_PERF_EN
        do_reset();
        set_scalar(0, 5'd1, 32'h1); set_scalar(1, 5'd2, 32'h2); set_scalar(2, 5'd3, 32'h3);
        cycle();
        clear_inputs();
        repeat (3) cycle();
        chk("perf_wb3", perf_wb_count, 32'd3);
        chk("perf_conf2", perf_conflict_cycles, 32'd2);
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            for (int s = 0; s < 3; s++) begin
                in_v[s]   = ($urandom_range(0, 9) < 6);
                in_rd[s]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                in_dat[s] = $urandom;
            end
            in_gv  = ($urandom_range(0, 9) < 5);
            in_gmd = 4'($urandom_range(0, 15));
            in_mv  = ($urandom_range(0, 9) < 5);
            in_mmd = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
